// File: rtl/rocks_pkg.sv
// Shared types and helpers for the rock pool: screen defaults, LFSR taps,
// 3-bit signed direction type, 10-bit coordinate type, and the LFSR/dir helpers.
package rocks_pkg;

  localparam int unsigned SCREEN_W_DEF = 640;
  localparam int unsigned SCREEN_H_DEF = 480;

  // Fibonacci taps at bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic signed [2:0] dir_t;
  typedef logic [9:0]        coord_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

  // Zero becomes +1. On the spawn edge axis the sign points inward;
  // -4 has no positive twin in 3 bits, so it becomes +3.
  function automatic dir_t dir_fix(input dir_t d, input logic on_edge,
                                   input logic neg);
    dir_t r;
    r = (d == 3'sd0) ? 3'sd1 : d;
    if (on_edge && neg && !r[2])
      r = -r;
    else if (on_edge && !neg && r[2])
      r = (r == 3'b100) ? 3'sd3 : -r;
    return r;
  endfunction

endpackage

// File: rtl/rock_slot.sv
// One rock slot: occupancy, position, velocity, per-frame move and exit.
// Ports: clk60hz/reset/enable_i, load_i + x_i/y_i/dx_i/dy_i spawn data,
// hit_i kill, px_i/py_i scan position, pixel_o coverage, in_use_o occupancy.
// ROCK_WRAP_EN: off-screen positions wrap instead of freeing the slot.
module rock_slot
  import rocks_pkg::*;
#(
  parameter int ROCK_SIZE = 16,
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF
) (
  input  logic   clk60hz,
  input  logic   reset,
  input  logic   enable_i,
  input  logic   load_i,
  input  logic   hit_i,
  input  coord_t x_i,
  input  coord_t y_i,
  input  dir_t   dx_i,
  input  dir_t   dy_i,
  input  coord_t px_i,
  input  coord_t py_i,
  output logic   pixel_o,
  output logic   in_use_o
);

  localparam coord_t SW = coord_t'(SCREEN_W);
  localparam coord_t SH = coord_t'(SCREEN_H);
  localparam coord_t RS = coord_t'(ROCK_SIZE);

  logic   in_use_q, in_use_d;
  coord_t x_q, x_d, y_q, y_d;
  dir_t   dx_q, dx_d, dy_q, dy_d;

  coord_t x_mv, y_mv, x_nx, y_nx;
  coord_t rx, ry;
  logic   leave;

  assign x_mv = x_q + {{7{dx_q[2]}}, dx_q};
  assign y_mv = y_q + {{7{dy_q[2]}}, dy_q};

`ifdef ROCK_WRAP_EN
  // Underflow shows up as a large value, so the velocity sign picks the fix.
  assign x_nx  = (x_mv > SW) ? (dx_q[2] ? x_mv + SW : x_mv - SW) : x_mv;
  assign y_nx  = (y_mv > SH) ? (dy_q[2] ? y_mv + SH : y_mv - SH) : y_mv;
  assign leave = 1'b0;
`else
  assign x_nx  = x_mv;
  assign y_nx  = y_mv;
  assign leave = (x_mv > SW) || (y_mv > SH);
`endif

  always_comb begin
    in_use_d = in_use_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    if (load_i) begin
      in_use_d = 1'b1;
      x_d      = x_i;
      y_d      = y_i;
      dx_d     = dx_i;
      dy_d     = dy_i;
    end else if (in_use_q) begin
      if (hit_i) begin
        in_use_d = 1'b0;
      end else if (enable_i) begin
        x_d      = x_nx;
        y_d      = y_nx;
        in_use_d = ~leave;
      end
    end
  end

  always_ff @(posedge clk60hz) begin
    if (reset) begin
      in_use_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
    end else begin
      in_use_q <= in_use_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
    end
  end

  assign rx       = px_i - x_q;
  assign ry       = py_i - y_q;
  assign pixel_o  = in_use_q & (rx < RS) & (ry < RS);
  assign in_use_o = in_use_q;

endmodule

// File: rtl/rock_pool_mgr.sv
// Asteroid pool: LFSR spawn source, spawn timer, lowest-free allocator,
// drop and live counters around NUM_ROCKS rock_slot instances.
// Ports: clk60hz, reset, enable, px/py scan, hit kills -> pixel,
// rocks_in_use, active_count, drop_count. ROCK_WRAP_EN selects wrapping.
module rock_pool_mgr
  import rocks_pkg::*;
#(
  parameter int          NUM_ROCKS    = 10,
  parameter int          SPAWN_PERIOD = 120,
  parameter int          ROCK_SIZE    = 16,
  parameter int          SCREEN_W     = SCREEN_W_DEF,
  parameter int          SCREEN_H     = SCREEN_H_DEF,
  parameter logic [15:0] SEED_A       = 16'hACE1,
  parameter logic [15:0] SEED_B       = 16'h1D2B
) (
  input  logic                 clk60hz,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [9:0]           px,
  input  logic [9:0]           py,
  input  logic [NUM_ROCKS-1:0] hit,
  output logic [NUM_ROCKS-1:0] pixel,
  output logic [NUM_ROCKS-1:0] rocks_in_use,
  output logic [4:0]           active_count,
  output logic [7:0]           drop_count
);

  localparam int          TW   = $clog2(SPAWN_PERIOD);
  localparam logic [TW-1:0] TERM = TW'(SPAWN_PERIOD - 1);
  localparam coord_t      SW   = coord_t'(SCREEN_W);
  localparam coord_t      SH   = coord_t'(SCREEN_H);

  logic [15:0]   lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    drop_q, drop_d;
  logic [4:0]    act_q, act_d;

  logic [NUM_ROCKS-1:0] in_use, load_vec;
  logic   spawn_now, full, neg;
  coord_t x_sp, y_sp, by;
  dir_t   dx_sp, dy_sp;

  assign spawn_now = enable & ~reset & (tmr_q == TERM);

  // Lowest free slot by registered occupancy; a slot freed on this edge
  // only becomes eligible on the next one.
  always_comb begin
    load_vec = '0;
    full     = 1'b1;
    for (int i = 0; i < NUM_ROCKS; i++) begin
      if (full && !in_use[i]) begin
        load_vec[i] = spawn_now;
        full        = 1'b0;
      end
    end
  end

  // A[11] picks the top/bottom edge versus the left/right edge.
  always_comb begin
    by  = {1'b0, lfsr_b_q[8:0]};
    neg = ~lfsr_a_q[10];
    if (lfsr_a_q[11]) begin
      x_sp  = {1'b0, lfsr_a_q[8:0]};
      y_sp  = lfsr_a_q[10] ? '0 : SH;
      dx_sp = dir_fix(dir_t'(lfsr_b_q[12:10]), 1'b0, neg);
      dy_sp = dir_fix(dir_t'(lfsr_b_q[15:13]), 1'b1, neg);
    end else begin
      x_sp  = lfsr_a_q[10] ? '0 : SW;
      y_sp  = (by < SH) ? by : by - 10'd256;
      dx_sp = dir_fix(dir_t'(lfsr_b_q[12:10]), 1'b1, neg);
      dy_sp = dir_fix(dir_t'(lfsr_b_q[15:13]), 1'b0, neg);
    end
  end

  always_comb begin
    lfsr_a_d = lfsr_step(lfsr_a_q);
    lfsr_b_d = lfsr_step(lfsr_b_q);
    tmr_d    = tmr_q;
    if (enable)
      tmr_d = spawn_now ? '0 : tmr_q + 1'b1;
    drop_d = drop_q;
    if (spawn_now && full && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
    act_d = '0;
    for (int i = 0; i < NUM_ROCKS; i++)
      act_d = act_d + 5'(in_use[i]);
  end

  always_ff @(posedge clk60hz) begin
    if (reset) begin
      lfsr_a_q <= SEED_A;
      lfsr_b_q <= SEED_B;
      tmr_q    <= '0;
      drop_q   <= '0;
      act_q    <= '0;
    end else begin
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      tmr_q    <= tmr_d;
      drop_q   <= drop_d;
      act_q    <= act_d;
    end
  end

  for (genvar g = 0; g < NUM_ROCKS; g++) begin : g_slot
    rock_slot #(
      .ROCK_SIZE(ROCK_SIZE),
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
    ) u_slot (
      .clk60hz (clk60hz),
      .reset   (reset),
      .enable_i(enable),
      .load_i  (load_vec[g]),
      .hit_i   (hit[g]),
      .x_i     (x_sp),
      .y_i     (y_sp),
      .dx_i    (dx_sp),
      .dy_i    (dy_sp),
      .px_i    (px),
      .py_i    (py),
      .pixel_o (pixel[g]),
      .in_use_o(in_use[g])
    );
  end

  assign rocks_in_use = in_use;
  assign active_count = act_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_rock_pool_mgr.sv
// Bench for rock_pool_mgr: directed phases plus a small reference model
// of the LFSRs, timer and slots checked every frame.
module tb_rock_pool_mgr;

  localparam int NR = 4;
  localparam int P  = 4;
  localparam int RS = 16;
  localparam int SW = 640;
  localparam int SH = 480;
  localparam logic [15:0] SA = 16'hACE1;
  localparam logic [15:0] SB = 16'h1D2B;

  logic          clk60hz = 1'b0;
  logic          reset, enable;
  logic [9:0]    px, py;
  logic [NR-1:0] hit, pixel, rocks_in_use;
  logic [4:0]    active_count;
  logic [7:0]    drop_count;

  int n_chk = 0;
  int n_err = 0;

  rock_pool_mgr #(
    .NUM_ROCKS(NR), .SPAWN_PERIOD(P), .ROCK_SIZE(RS),
    .SCREEN_W(SW), .SCREEN_H(SH), .SEED_A(SA), .SEED_B(SB)
  ) dut (
    .clk60hz(clk60hz), .reset(reset), .enable(enable),
    .px(px), .py(py), .hit(hit), .pixel(pixel),
    .rocks_in_use(rocks_in_use), .active_count(active_count),
    .drop_count(drop_count)
  );

  always #5 clk60hz = ~clk60hz;

  // reference state
  logic [15:0] ma, mb;
  int mt, mdrop, mact;
  bit mu[NR];
  int mx[NR], my[NR], mdx[NR], mdy[NR];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  function automatic int mdir(input logic [2:0] r, input bit on_edge,
                              input bit pos);
    int v;
    v = int'($signed(r));
    if (v == 0) v = 1;
    if (on_edge && pos && v < 0) v = (v == -4) ? 3 : -v;
    if (on_edge && !pos && v > 0) v = -v;
    return v;
  endfunction

  function automatic logic [NR-1:0] mvec();
    logic [NR-1:0] r;
    for (int i = 0; i < NR; i++) r[i] = mu[i];
    return r;
  endfunction

  function automatic logic [NR-1:0] mpix(input int qx, input int qy);
    logic [NR-1:0] r;
    for (int i = 0; i < NR; i++)
      r[i] = mu[i] && (((qx - mx[i]) & 1023) < RS)
                   && (((qy - my[i]) & 1023) < RS);
    return r;
  endfunction

  task automatic model_step(input bit en, input bit rs,
                            input logic [NR-1:0] h);
    bit old[NR];
    bit spawn, placed;
    int sx, sy, sdx, sdy, sb, nx, ny, cnt;
    if (rs) begin
      ma = SA; mb = SB; mt = 0; mdrop = 0; mact = 0;
      for (int i = 0; i < NR; i++) begin
        mu[i] = 0; mx[i] = 0; my[i] = 0; mdx[i] = 0; mdy[i] = 0;
      end
      return;
    end
    spawn = en && (mt == P - 1);
    if (ma[11]) begin
      sx  = int'(ma[8:0]);
      sy  = ma[10] ? 0 : SH;
      sdx = mdir(mb[12:10], 0, 0);
      sdy = mdir(mb[15:13], 1, ma[10]);
    end else begin
      sb  = int'(mb[8:0]);
      sx  = ma[10] ? 0 : SW;
      sy  = (sb < SH) ? sb : sb - 256;
      sdx = mdir(mb[12:10], 1, ma[10]);
      sdy = mdir(mb[15:13], 0, 0);
    end
    cnt = 0;
    for (int i = 0; i < NR; i++) begin
      old[i] = mu[i];
      cnt += int'(mu[i]);
    end
    for (int i = 0; i < NR; i++) begin
      if (old[i]) begin
        if (h[i]) mu[i] = 0;
        else if (en) begin
          nx = (mx[i] + mdx[i]) & 1023;
          ny = (my[i] + mdy[i]) & 1023;
`ifdef ROCK_WRAP_EN
          if (nx > SW) nx = (mdx[i] < 0) ? (nx + SW) & 1023 : nx - SW;
          if (ny > SH) ny = (mdy[i] < 0) ? (ny + SH) & 1023 : ny - SH;
`else
          if (nx > SW || ny > SH) mu[i] = 0;
`endif
          mx[i] = nx; my[i] = ny;
        end
      end
    end
    if (spawn) begin
      placed = 0;
      for (int i = 0; i < NR; i++) begin
        if (!placed && !old[i]) begin
          mu[i] = 1; mx[i] = sx; my[i] = sy;
          mdx[i] = sdx; mdy[i] = sdy; placed = 1;
        end
      end
      if (!placed && mdrop < 255) mdrop++;
    end
    if (en) mt = spawn ? 0 : mt + 1;
    ma = lstep(ma); mb = lstep(mb); mact = cnt;
  endtask

  task automatic cmp_all();
    int j, qx, qy;
    j = -1;
    for (int i = NR - 1; i >= 0; i--) if (mu[i]) j = i;
    qx = (j < 0) ? 0 : mx[j];
    qy = (j < 0) ? 0 : my[j];
    chk("use", 32'(rocks_in_use), 32'(mvec()));
    chk("act", 32'(active_count), 32'(mact));
    chk("drop", 32'(drop_count), 32'(mdrop));
    px = 10'(qx); py = 10'(qy);
    #1 chk("pix_in", 32'(pixel), 32'(mpix(qx, qy)));
    px = 10'((qx - 1) & 1023);
    #1 chk("pix_out", 32'(pixel), 32'(mpix((qx - 1) & 1023, qy)));
  endtask

  task automatic tick(input bit en, input bit rs, input logic [NR-1:0] h);
    enable = en; reset = rs; hit = h;
    @(posedge clk60hz);
    model_step(en, rs, h);
    #1;
    cmp_all();
  endtask

  initial begin
    logic [NR-1:0] u0;
    int dprev, n;
    bit found;
    reset = 1'b1; enable = 1'b0; hit = '0; px = '0; py = '0;
    tick(0, 1, '0);
    tick(0, 1, '0);
    px = '0; py = '0;
    #1;
    chk("rst_use", 32'(rocks_in_use), 32'h0);
    chk("rst_act", 32'(active_count), 32'h0);
    chk("rst_drop", 32'(drop_count), 32'h0);
    chk("rst_pix", 32'(pixel), 32'h0);

    // first spawn lands exactly P enabled frames after reset
    for (int k = 0; k < P - 1; k++) tick(1, 0, '0);
    chk("pre_spawn", 32'(rocks_in_use), 32'h0);
    tick(1, 0, '0);
    chk("spawn0", 32'(rocks_in_use), 32'h1);
    chk("act_lag", 32'(active_count), 32'h0);
    px = 10'((mx[0] + 15) & 1023); py = 10'((my[0] + 15) & 1023);
    #1 chk("pix_edge_in", 32'(pixel), 32'h1);
    px = 10'((mx[0] + 16) & 1023);
    #1 chk("pix_x_past", 32'(pixel), 32'h0);
    px = 10'((mx[0] - 1) & 1023); py = 10'(my[0]);
    #1 chk("pix_x_before", 32'(pixel), 32'h0);
    tick(1, 0, '0);
    chk("act1", 32'(active_count), 32'h1);

    for (int k = 0; k < 200; k++) tick(1, 0, '0);

    // pause: nothing moves or spawns
    u0 = mvec();
    for (int k = 0; k < 3 * P; k++) tick(0, 0, '0);
    chk("pause_hold", 32'(rocks_in_use), 32'(u0));

    // reset mid-flight on a spawn cycle
    found = 0;
    for (n = 0; n < 200 && !found; n++) begin
      if (mt == P - 1 && mvec() != '0) found = 1;
      else tick(1, 0, '0);
    end
    if (!found) chk("rst_wait_timeout", 32'h0, 32'h1);
    tick(1, 1, '1);
    chk("mid_rst_use", 32'(rocks_in_use), 32'h0);
    chk("mid_rst_drop", 32'(drop_count), 32'h0);
    tick(1, 0, '0);
    chk("mid_rst_act", 32'(active_count), 32'h0);

    // hit slot 2 on a spawn cycle with the pool full
    found = 0;
    for (n = 0; n < 4000 && !found; n++) begin
      if (mt == P - 1 && mvec() == '1) found = 1;
      else tick(1, 0, '0);
    end
    if (!found) chk("full_wait_timeout", 32'h0, 32'h1);
    dprev = mdrop;
    tick(1, 0, 4'b0100);
    chk("hit_free", 32'(rocks_in_use[2]), 32'h0);
    chk("hit_drop", 32'(drop_count), 32'(dprev + 1));
    for (int k = 0; k < P - 1; k++) begin
      tick(1, 0, (k == 0) ? 4'b0100 : 4'b0000);
      chk("hit_gap", 32'(rocks_in_use[2]), 32'h0);
    end
    tick(1, 0, '0);

    // drop counter saturates
    for (n = 0; n < 30000 && mdrop < 255; n++) tick(1, 0, '0);
    if (mdrop < 255) chk("sat_wait_timeout", 32'h0, 32'h1);
    chk("drop_sat", 32'(drop_count), 32'd255);
    for (int k = 0; k < 8 * P; k++) tick(1, 0, '0);
    chk("drop_hold", 32'(drop_count), 32'd255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
